// File: rtl/vga_timing_gen_if.sv
// Video timing bus: clock enable in, fetch-side and video-side timing out.
// The generator drives it through the master modport; consumers use slave.
interface vga_timing_gen_if #(
    parameter int WIDTH   = 10,
    parameter int FRAME_W = 8
);
    logic               ce;
    logic               fetch_valid;
    logic [WIDTH-1:0]   fetch_x;
    logic [WIDTH-1:0]   fetch_y;
    logic               hsync;
    logic               vsync;
    logic               de;
    logic [WIDTH-1:0]   xpos;
    logic [WIDTH-1:0]   ypos;
    logic               line_start;
    logic               frame_start;
    logic [FRAME_W-1:0] frame_cnt;

    modport master (
        input  ce,
        output fetch_valid, fetch_x, fetch_y,
        output hsync, vsync, de, xpos, ypos,
        output line_start, frame_start, frame_cnt
    );

    modport slave (
        output ce,
        input  fetch_valid, fetch_x, fetch_y,
        input  hsync, vsync, de, xpos, ypos,
        input  line_start, frame_start, frame_cnt
    );
endinterface

// File: rtl/vga_timing_gen.sv
// Parametrised video timing generator. A fetch-side coordinate stream leaves
// stage F; the video-side outputs follow LEAD cycles later through a register
// chain, so memories with LEAD cycles of read latency line up with de.
module vga_timing_gen #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int H_POL    = 0,
    parameter int V_POL    = 0,
    parameter int LEAD     = 1,
    parameter int WIDTH    = 10,
    parameter int FRAME_W  = 8
) (
    input  logic                pixel_clk,
    input  logic                rst,
    vga_timing_gen_if.master    bus
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    // Region boundaries; all of them are below 2**WIDTH once the checks hold.
    localparam logic [WIDTH-1:0] H_ACT_END    = WIDTH'(H_ACTIVE);
    localparam logic [WIDTH-1:0] H_SYNC_START = WIDTH'(H_ACTIVE + H_FP);
    localparam logic [WIDTH-1:0] H_SYNC_END   = WIDTH'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [WIDTH-1:0] H_LAST       = WIDTH'(H_TOTAL - 1);
    localparam logic [WIDTH-1:0] V_ACT_END    = WIDTH'(V_ACTIVE);
    localparam logic [WIDTH-1:0] V_SYNC_START = WIDTH'(V_ACTIVE + V_FP);
    localparam logic [WIDTH-1:0] V_SYNC_END   = WIDTH'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [WIDTH-1:0] V_LAST       = WIDTH'(V_TOTAL - 1);

    localparam logic HS_IDLE   = (H_POL == 0) ? 1'b1 : 1'b0;
    localparam logic HS_ACTIVE = ~HS_IDLE;
    localparam logic VS_IDLE   = (V_POL == 0) ? 1'b1 : 1'b0;
    localparam logic VS_ACTIVE = ~VS_IDLE;

    generate
        if (H_ACTIVE < 1 || H_FP < 1 || H_SYNC < 1 || H_BP < 1 ||
            V_ACTIVE < 1 || V_FP < 1 || V_SYNC < 1 || V_BP < 1 ||
            H_TOTAL > (2 ** WIDTH) || V_TOTAL > (2 ** WIDTH) ||
            LEAD < 0 || LEAD > 7 || FRAME_W < 1) begin : g_badParams
            $error("vga_timing_gen: illegal timing parameters");
        end
    endgenerate

    // One pipeline slot; sync levels are stored already polarity-applied so
    // that every output comes straight from a flop.
    typedef struct packed {
        logic             vis;
        logic             hsync;
        logic             vsync;
        logic             ls;
        logic             fs;
        logic [WIDTH-1:0] x;
        logic [WIDTH-1:0] y;
    } stage_t;

    localparam stage_t STAGE_RST = '{vis: 1'b0, hsync: HS_IDLE, vsync: VS_IDLE,
                                     ls: 1'b0, fs: 1'b0, x: '0, y: '0};

    logic [WIDTH-1:0]   r_hcnt;
    logic [WIDTH-1:0]   r_vcnt;
    logic [FRAME_W-1:0] r_frameCnt;
    stage_t             r_stageF;
    stage_t             w_stageNext;
    stage_t             w_video;
    logic               w_hActive;
    logic               w_hSync;
    logic               w_vActive;
    logic               w_vSync;

    // Raster counters: column wraps every line, row steps on the column wrap.
    always_ff @(posedge pixel_clk or posedge rst) begin
        if (rst) begin
            r_hcnt <= '0;
            r_vcnt <= '0;
        end else if (bus.ce) begin
            if (r_hcnt == H_LAST) begin
                r_hcnt <= '0;
                if (r_vcnt == V_LAST) begin
                    r_vcnt <= '0;
                end else begin
                    r_vcnt <= r_vcnt + WIDTH'(1);
                end
            end else begin
                r_hcnt <= r_hcnt + WIDTH'(1);
            end
        end
    end

    // Region decode of the current counter position into a pipeline slot.
    always_comb begin
        w_hActive   = (r_hcnt < H_ACT_END);
        w_hSync     = (r_hcnt >= H_SYNC_START) && (r_hcnt < H_SYNC_END);
        w_vActive   = (r_vcnt < V_ACT_END);
        w_vSync     = (r_vcnt >= V_SYNC_START) && (r_vcnt < V_SYNC_END);
        w_stageNext = STAGE_RST;
        w_stageNext.vis   = w_hActive && w_vActive;
        w_stageNext.hsync = w_hSync ? HS_ACTIVE : HS_IDLE;
        w_stageNext.vsync = w_vSync ? VS_ACTIVE : VS_IDLE;
        w_stageNext.ls    = (r_hcnt == '0) && w_vActive;
        w_stageNext.fs    = (r_hcnt == '0) && (r_vcnt == '0);
        if (w_hActive && w_vActive) begin
            w_stageNext.x = r_hcnt;
            w_stageNext.y = r_vcnt;
        end
    end

    // Stage F: registered decode, which is also the fetch-side output.
    always_ff @(posedge pixel_clk or posedge rst) begin
        if (rst) begin
            r_stageF <= STAGE_RST;
        end else if (bus.ce) begin
            r_stageF <= w_stageNext;
        end
    end

    generate
        if (LEAD == 0) begin : g_noLead
            assign w_video = r_stageF;
        end else begin : g_lead
            stage_t r_chain [LEAD];

            // Delay line that holds the video side LEAD slots behind fetch.
            always_ff @(posedge pixel_clk or posedge rst) begin
                if (rst) begin
                    for (int i = 0; i < LEAD; i++) begin
                        r_chain[i] <= STAGE_RST;
                    end
                end else if (bus.ce) begin
                    r_chain[0] <= r_stageF;
                    for (int i = 1; i < LEAD; i++) begin
                        r_chain[i] <= r_chain[i-1];
                    end
                end
            end

            assign w_video = r_chain[LEAD-1];
        end
    endgenerate

    // Count frames as the video-side frame strobe is consumed.
    always_ff @(posedge pixel_clk or posedge rst) begin
        if (rst) begin
            r_frameCnt <= '0;
        end else if (bus.ce && w_video.fs) begin
            r_frameCnt <= r_frameCnt + FRAME_W'(1);
        end
    end

    assign bus.fetch_valid = r_stageF.vis;
    assign bus.fetch_x     = r_stageF.x;
    assign bus.fetch_y     = r_stageF.y;
    assign bus.de          = w_video.vis;
    assign bus.hsync       = w_video.hsync;
    assign bus.vsync       = w_video.vsync;
    assign bus.line_start  = w_video.ls;
    assign bus.frame_start = w_video.fs;
    assign bus.xpos        = w_video.x;
    assign bus.ypos        = w_video.y;
    assign bus.frame_cnt   = r_frameCnt;
endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: a tiny LEAD=2 instance driven with random clock
// enables and a full-size 640x480 LEAD=0 instance, both compared each cycle
// against a raster model computed from the edge count since reset.
module tb_vga_timing_gen;
    localparam int T_HA = 4, T_HF = 1, T_HS = 2, T_HB = 1;
    localparam int T_VA = 3, T_VF = 1, T_VS = 1, T_VB = 1;
    localparam int T_LEAD = 2, T_W = 4, T_FW = 2;
    localparam int T_FRAME = (T_HA + T_HF + T_HS + T_HB) * (T_VA + T_VF + T_VS + T_VB);

    typedef struct {
        bit     fv;
        longint fx;
        longint fy;
        bit     de;
        longint x;
        longint y;
        bit     hs;
        bit     vs;
        bit     ls;
        bit     fs;
        longint fc;
    } exp_t;

    logic   clk;
    logic   rst;
    longint kTiny;
    longint kBig;
    int     assertCount;
    int     failCount;

    vga_timing_gen_if #(.WIDTH(T_W), .FRAME_W(T_FW)) tinyBus ();
    vga_timing_gen_if #(.WIDTH(10), .FRAME_W(8))     bigBus ();

    vga_timing_gen #(
        .H_ACTIVE(T_HA), .H_FP(T_HF), .H_SYNC(T_HS), .H_BP(T_HB),
        .V_ACTIVE(T_VA), .V_FP(T_VF), .V_SYNC(T_VS), .V_BP(T_VB),
        .H_POL(0), .V_POL(0), .LEAD(T_LEAD), .WIDTH(T_W), .FRAME_W(T_FW)
    ) dutTiny (
        .pixel_clk(clk),
        .rst(rst),
        .bus(tinyBus)
    );

    vga_timing_gen #(
        .H_ACTIVE(640), .H_FP(16), .H_SYNC(96), .H_BP(48),
        .V_ACTIVE(480), .V_FP(10), .V_SYNC(2), .V_BP(33),
        .H_POL(1), .V_POL(1), .LEAD(0), .WIDTH(10), .FRAME_W(8)
    ) dutBig (
        .pixel_clk(clk),
        .rst(rst),
        .bus(bigBus)
    );

    // Free-running pixel clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Expected outputs after k enabled edges: fetch shows raster position
    // k-1, video shows position k-1-lead, frames counted from strobes seen.
    function automatic exp_t model(input int hA, hF, hS, hB, vA, vF, vS, vB,
                                   input int lead, hPol, vPol, frameW,
                                   input longint k);
        longint ht = hA + hF + hS + hB;
        longint vt = vA + vF + vS + vB;
        longint ft = ht * vt;
        longint n, h, v, m;
        exp_t e;
        e.fv = 0; e.fx = 0; e.fy = 0;
        e.de = 0; e.x = 0; e.y = 0;
        e.hs = (hPol == 0); e.vs = (vPol == 0);
        e.ls = 0; e.fs = 0; e.fc = 0;
        if (k >= 1) begin
            n = k - 1;
            h = n % ht;
            v = (n / ht) % vt;
            if (h < hA && v < vA) begin
                e.fv = 1; e.fx = h; e.fy = v;
            end
        end
        if (k - 1 - lead >= 0) begin
            n = k - 1 - lead;
            h = n % ht;
            v = (n / ht) % vt;
            if (h < hA && v < vA) begin
                e.de = 1; e.x = h; e.y = v;
            end
            if (h >= hA + hF && h < hA + hF + hS) e.hs = (hPol != 0);
            if (v >= vA + vF && v < vA + vF + vS) e.vs = (vPol != 0);
            e.ls = (h == 0) && (v < vA);
            e.fs = (n % ft == 0);
        end
        m = k - 2 - lead;
        if (m >= 0) e.fc = (m / ft + 1) % (longint'(1) << frameW);
        return e;
    endfunction

    task automatic checkOutput(input string tag, input longint observed, input longint expected);
        assertCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s at %0t: got %0d, expected %0d", tag, $time, observed, expected);
        end
    endtask

    task automatic checkTiny();
        exp_t e = model(T_HA, T_HF, T_HS, T_HB, T_VA, T_VF, T_VS, T_VB,
                        T_LEAD, 0, 0, T_FW, kTiny);
        checkOutput("tinyFetchValid", tinyBus.fetch_valid, e.fv);
        checkOutput("tinyFetchX", tinyBus.fetch_x, e.fx);
        checkOutput("tinyFetchY", tinyBus.fetch_y, e.fy);
        checkOutput("tinyDe", tinyBus.de, e.de);
        checkOutput("tinyXpos", tinyBus.xpos, e.x);
        checkOutput("tinyYpos", tinyBus.ypos, e.y);
        checkOutput("tinyHsync", tinyBus.hsync, e.hs);
        checkOutput("tinyVsync", tinyBus.vsync, e.vs);
        checkOutput("tinyLineStart", tinyBus.line_start, e.ls);
        checkOutput("tinyFrameStart", tinyBus.frame_start, e.fs);
        checkOutput("tinyFrameCnt", tinyBus.frame_cnt, e.fc);
        if (kTiny == 1) begin
            checkOutput("tinyFirstFetchValid", tinyBus.fetch_valid, 1);
            checkOutput("tinyFirstFetchX", tinyBus.fetch_x, 0);
            checkOutput("tinyEarlyDe", tinyBus.de, 0);
        end
        if (kTiny == 3) begin
            checkOutput("tinyFirstDe", tinyBus.de, 1);
            checkOutput("tinyFirstFrameStart", tinyBus.frame_start, 1);
            checkOutput("tinyFirstXY", {tinyBus.xpos, tinyBus.ypos}, 0);
        end
    endtask

    task automatic checkBig();
        exp_t e = model(640, 16, 96, 48, 480, 10, 2, 33, 0, 1, 1, 8, kBig);
        checkOutput("bigFetchValid", bigBus.fetch_valid, e.fv);
        checkOutput("bigFetchX", bigBus.fetch_x, e.fx);
        checkOutput("bigFetchY", bigBus.fetch_y, e.fy);
        checkOutput("bigDe", bigBus.de, e.de);
        checkOutput("bigXpos", bigBus.xpos, e.x);
        checkOutput("bigYpos", bigBus.ypos, e.y);
        checkOutput("bigHsync", bigBus.hsync, e.hs);
        checkOutput("bigVsync", bigBus.vsync, e.vs);
        checkOutput("bigLineStart", bigBus.line_start, e.ls);
        checkOutput("bigFrameStart", bigBus.frame_start, e.fs);
        checkOutput("bigFrameCnt", bigBus.frame_cnt, e.fc);
    endtask

    // Drives the tiny instance's enable for one edge, then checks both.
    task automatic applyStimulus(input bit ceValue);
        tinyBus.ce = ceValue;
        @(posedge clk);
        if (!rst && ceValue) kTiny++;
        if (!rst) kBig++;
        #1;
        checkTiny();
        checkBig();
    endtask

    // Main sequence: power-up, stall, random enables, mid-frame reset.
    initial begin
        int guard;
        bit found;
        assertCount = 0;
        failCount   = 0;
        kTiny       = 0;
        kBig        = 0;
        rst         = 1'b1;
        tinyBus.ce  = 1'b0;
        bigBus.ce   = 1'b1;

        repeat (3) @(posedge clk);
        #1;
        checkTiny();
        checkBig();
        rst = 1'b0;

        for (int i = 0; i < 60; i++) applyStimulus(1'b1);
        for (int i = 0; i < 10; i++) applyStimulus(1'b0);

        guard = 0;
        while (kTiny < 5 * T_FRAME + 20 && guard < 2000) begin
            applyStimulus($urandom_range(0, 3) != 0);
            guard++;
        end
        checkOutput("tinyRandomProgress", kTiny >= 5 * T_FRAME + 20, 1);

        found = 1'b0;
        guard = 0;
        while (!found && guard < 200) begin
            applyStimulus(1'b1);
            found = tinyBus.de && (tinyBus.ypos == 2);
            guard++;
        end
        checkOutput("tinyReachLine2", found, 1);

        #2;
        rst = 1'b1;
        #1;
        kTiny = 0;
        kBig  = 0;
        checkOutput("asyncDe", tinyBus.de, 0);
        checkOutput("asyncFetchValid", tinyBus.fetch_valid, 0);
        checkOutput("asyncFrameCnt", tinyBus.frame_cnt, 0);
        checkOutput("asyncHsync", tinyBus.hsync, 1);
        checkOutput("asyncVsync", tinyBus.vsync, 1);
        checkTiny();
        checkBig();
        for (int i = 0; i < 3; i++) applyStimulus(1'b1);
        rst = 1'b0;

        for (int i = 0; i < 60; i++) applyStimulus(1'b1);
        for (int i = 0; i < 2500; i++) applyStimulus($urandom_range(0, 3) != 0);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end
endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
Parametrised VGA/video timing generator, the successor to the fixed 640x480 controller. It produces hsync and vsync with configurable polarity, a data-enable, pixel coordinates, and line/frame start strobes. A separate fetch-side coordinate stream runs LEAD cycles ahead of the video outputs, so frame-buffer or detector memories with LEAD-cycle read latency line up exactly with de. It sits between the pixel clock domain and the image memory / RGB output mux.

Parameters:
H_ACTIVE, 640, visible pixels per line
H_FP, 16, horizontal front porch (cycles)
H_SYNC, 96, hsync pulse width (cycles)
H_BP, 48, horizontal back porch (cycles)
V_ACTIVE, 480, visible lines per frame
V_FP, 10, vertical front porch (lines)
V_SYNC, 2, vsync pulse width (lines)
V_BP, 33, vertical back porch (lines)
H_POL, 0, hsync active level (0 = active-low)
V_POL, 0, vsync active level
LEAD, 1, cycles by which fetch outputs precede video outputs (0..7)
WIDTH, 10, counter/coordinate width; must hold H_TOTAL-1 and V_TOTAL-1
FRAME_W, 8, frame counter width

Ports:
pixel_clk  in  1  pixel clock
rst  in  1  asynchronous reset, active-high
ce  in  1  clock enable; 0 freezes all state
fetch_valid  out  1  fetch coordinate is a visible pixel
fetch_x  out  WIDTH  fetch column (0 when !fetch_valid)
fetch_y  out  WIDTH  fetch row (0 when !fetch_valid)
hsync  out  1  horizontal sync, level per H_POL
vsync  out  1  vertical sync, level per V_POL
de  out  1  video data enable
xpos  out  WIDTH  video column (0 when !de)
ypos  out  WIDTH  video row (0 when !de)
line_start  out  1  first cycle of a visible line (video-aligned)
frame_start  out  1  first cycle of a frame (video-aligned)
frame_cnt  out  FRAME_W  frames started since reset, wraps

Behaviour:
- H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP. V_TOTAL is the analogous sum of the V_* parameters. All parameters are >=1 and both totals are <= 2**WIDTH; a generate-time error is raised otherwise.
- Counters: hcnt runs 0..H_TOTAL-1. vcnt runs 0..V_TOTAL-1 and advances only when hcnt wraps to 0. vcnt wraps to 0 after V_TOTAL-1. Both advance only when ce=1.
- Region order, per line and per frame: active, front porch, sync, back porch.
  - h active: hcnt < H_ACTIVE.
  - h sync: H_ACTIVE+H_FP <= hcnt < H_ACTIVE+H_FP+H_SYNC.
  - v regions use the same form with vcnt and the V_* parameters.
- Decode, combinational from the counters:
  - vis = h active && v active.
  - hs = h sync.
  - vs = v sync, held for whole lines, so it changes only on the hcnt=0 boundary.
  - ls = (hcnt==0 && v active).
  - fs = (hcnt==0 && vcnt==0).
- Pipeline stage F registers the decode. fetch_valid=vis; fetch_x/fetch_y are hcnt/vcnt when vis, else 0.
- Stage F is followed by a LEAD-deep register chain carrying vis, hs, vs, ls, fs, x and y.
  - Chain output drives de, hsync (= hs ? H_POL : !H_POL), vsync (same form with V_POL), line_start, frame_start, xpos and ypos.
  - LEAD=0: video outputs equal the stage-F values in the same cycle.
- Timing: at the k-th ce-qualified edge after reset release, stage F reflects counter state k-1. Video outputs reflect counter state k-1-LEAD.
- frame_cnt increments on each ce-qualified edge where the video-side frame_start is 1, and wraps modulo 2**FRAME_W.
- ce=0:
  - Counters, every pipeline stage and frame_cnt hold.
  - Outputs remain static, so strobes stay high while frozen. Consumers qualify line_start/frame_start with ce.
- Reset (rst=1, asynchronous):
  - hcnt=vcnt=0.
  - All stages read as inactive: fetch_valid=de=line_start=frame_start=0, coordinates 0.
  - hsync=!H_POL, vsync=!V_POL, frame_cnt=0.
  - Reset mid-frame discards the in-flight pipeline immediately. After release, timing restarts at pixel (0,0) exactly as after power-up.
- No glitches: every output is a flop output.

Test Plan:
- Tiny config (H 4/1/2/1, V 3/1/1/1, LEAD=2, pols 0) -> after release, fetch_valid first 1 at edge 1 with fetch_x=0, de first 1 at edge 3 with xpos=0, ypos=0; frame_start=1 at edge 3; each frame is 48 cycles.
- Same config, count per line -> de high 4 cycles with xpos 0,1,2,3; hsync low exactly 2 cycles starting 5 cycles after line_start; 3 line_start pulses per frame.
- vsync check -> vsync low for exactly 8 consecutive cycles (1 line) beginning at video line 4, hcnt 0; de=0 on lines 3..5.
- Default 640x480 config, LEAD=0, H_POL=V_POL=1 -> 800-cycle lines, 525-line frames, 307200 de cycles per frame, hsync high 96 cycles starting 16 after de falls.
- Tiny config, FRAME_W=2; hold ce low for 10 cycles mid-line, then run 5 frames -> outputs frozen during the stall; frame_cnt sequence 1,2,3,0,1.
- Assert rst during the active region of line 2 -> de, fetch_valid and frame_cnt drop to 0 asynchronously, with hsync/vsync at inactive level; after release, the first-frame timing of test 1 repeats exactly.
